// File: rtl/lsu_mem_responder_pkg.sv
// Shared types, request-bus field offsets and the sub-word write merge for the LSU memory responder.
package lsu_mem_responder_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    WselWord = 2'b00,
    WselHalf = 2'b01,
    WselByte = 2'b10,
    WselNone = 2'b11
  } wsel_e;

  // R_request = {ren, raddr}; W_request = {w_sel, wen, waddr, wdata}
  localparam int unsigned RADDR_LSB = 0;
  localparam int unsigned WDATA_LSB = 0;
  localparam int unsigned WADDR_LSB = DATA_W;

  function automatic int unsigned ren_pos(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned wen_pos(input int unsigned aw);
    return DATA_W + aw;
  endfunction

  function automatic int unsigned wsel_lsb(input int unsigned aw);
    return DATA_W + aw + 1;
  endfunction

  function automatic logic [DATA_W-1:0] merge_write(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input wsel_e             sel);
    logic [DATA_W-1:0] res;
    res = old_w;
    unique case (sel)
      WselWord: res = new_w;
      WselHalf: res = {old_w[31:16], new_w[15:0]};
      WselByte: res = {old_w[31:8], new_w[7:0]};
      default:  res = old_w;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_mem_responder_rd_pend_fifo.sv
// In-order pending-read address FIFO; a push while full is accepted only alongside a pop.
module rd_pend_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         data_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] store_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = store_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone defines which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) store_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/lsu_mem_responder.sv
// LSU memory endpoint: single-port scratchpad with write-priority arbitration, an in-order
// pending-read queue and a fixed-latency read response pipeline.
module lsu_mem_responder
  import lsu_mem_responder_pkg::*;
#(
  parameter int unsigned A_W      = 8,
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned PQ_DEPTH = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [A_W:0]                R_request,
  input  logic [A_W+34:0]             W_request,
  output logic [32:0]                 CBG_to_LSU_bus,
  output logic [$clog2(PQ_DEPTH):0]   pq_level,
  output logic                        pq_overflow,
  output logic [CNT_W-1:0]            drop_cnt
);

  localparam int unsigned Words   = 2 ** A_W;
  localparam int unsigned RenPos  = ren_pos(A_W);
  localparam int unsigned WenPos  = wen_pos(A_W);
  localparam int unsigned WselLsb = wsel_lsb(A_W);

  logic              ren, wen;
  logic [A_W-1:0]    raddr, waddr, head_addr, svc_addr;
  logic [31:0]       wdata;
  wsel_e             wsel;
  logic              wr_valid, q_empty, q_full, q_pop, q_push, push_req, drop, direct, svc_valid;

  logic [31:0]       mem_q [Words];
  logic [READ_LAT-1:0] vld_q;
  logic [31:0]       dat_q [READ_LAT];
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign ren   = R_request[RenPos];
  assign raddr = R_request[RADDR_LSB +: A_W];
  assign wdata = W_request[WDATA_LSB +: 32];
  assign waddr = W_request[WADDR_LSB +: A_W];
  assign wen   = W_request[WenPos];
  assign wsel  = wsel_e'(W_request[WselLsb +: 2]);

  // Arbitration: write, then queued read, then incoming read; later reads queue behind earlier.
  always_comb begin
    wr_valid  = wen && (wsel != WselNone);
    q_pop     = !wr_valid && !q_empty;
    direct    = !wr_valid && q_empty && ren;
    push_req  = ren && !direct;
    drop      = push_req && q_full && !q_pop;
    q_push    = push_req && !drop;
    svc_valid = q_pop || direct;
    svc_addr  = q_pop ? head_addr : raddr;
    ovf_d     = ovf_q || drop;
    cnt_d     = (drop && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  end

  rd_pend_fifo #(
    .Width (A_W),
    .Depth (PQ_DEPTH)
  ) u_rd_pend_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .data_i  (raddr),
    .data_o  (head_addr),
    .full_o  (q_full),
    .empty_o (q_empty),
    .level_o (pq_level)
  );

  always_ff @(posedge clk) begin
    if (wr_valid) mem_q[waddr] <= merge_write(mem_q[waddr], wdata, wsel);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LAT; i++) dat_q[i] <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q[0] <= svc_valid;
      dat_q[0] <= svc_valid ? mem_q[svc_addr] : '0;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign CBG_to_LSU_bus = vld_q[READ_LAT-1] ? {1'b1, dat_q[READ_LAT-1]} : 33'd0;
  assign pq_overflow    = ovf_q;
  assign drop_cnt       = cnt_q;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder with default parameters (A_W=8, READ_LAT=2, PQ_DEPTH=4).
module tb_lsu_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  R_request;
  logic [42:0] W_request;
  logic [32:0] CBG_to_LSU_bus;
  logic [2:0]  pq_level;
  logic        pq_overflow;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  lsu_mem_responder dut (
    .clk            (clk),
    .rst            (rst),
    .R_request      (R_request),
    .W_request      (W_request),
    .CBG_to_LSU_bus (CBG_to_LSU_bus),
    .pq_level       (pq_level),
    .pq_overflow    (pq_overflow),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rsp(input logic [31:0] d);
    return {31'd0, 1'b1, d};
  endfunction

  task automatic drive(input logic ren, input logic [7:0] ra, input logic wen,
                       input logic [1:0] ws, input logic [7:0] wa, input logic [31:0] wd);
    R_request = {ren, ra};
    W_request = {ws, wen, wa, wd};
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 2'b00, 8'h00, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  a;
    logic [31:0] exp5 [3];
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus", 64'(CBG_to_LSU_bus), 64'd0);
    check("rst_level", 64'(pq_level), 64'd0);
    check("rst_ovf", 64'(pq_overflow), 64'd0);
    check("rst_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1: write then read one cycle later
    drive(1'b0, 8'h00, 1'b1, 2'b00, 8'h10, 32'h12345678);
    tick();
    drive(1'b1, 8'h10, 1'b0, 2'b00, 8'h00, 32'h0);
    tick();
    idle();
    check("t1_s1", 64'(CBG_to_LSU_bus), 64'd0);
    tick();
    check("t1_s2", 64'(CBG_to_LSU_bus), rsp(32'h12345678));
    tick();
    check("t1_s3", 64'(CBG_to_LSU_bus), 64'd0);

    // 2: sub-word writes and the reserved size
    drive(1'b0, 8'h00, 1'b1, 2'b00, 8'h20, 32'hFFFFFFFF);
    tick();
    drive(1'b0, 8'h00, 1'b1, 2'b01, 8'h20, 32'h0000ABCD);
    tick();
    drive(1'b0, 8'h00, 1'b1, 2'b10, 8'h20, 32'h00000011);
    tick();
    drive(1'b1, 8'h20, 1'b1, 2'b11, 8'h20, 32'h0);
    tick();
    idle();
    check("t2_none_level", 64'(pq_level), 64'd0);
    tick();
    check("t2_merge", 64'(CBG_to_LSU_bus), rsp(32'hFFFFAB11));
    tick();

    // preload words for the ordering and wrap tests
    drive(1'b0, 8'h00, 1'b1, 2'b00, 8'h01, 32'hA1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 2'b00, 8'h03, 32'hA3);
    tick();
    drive(1'b0, 8'h00, 1'b1, 2'b00, 8'h04, 32'hA4);
    tick();
    exp5[0] = 32'hE0E000FE;
    exp5[1] = 32'hE0E000FF;
    exp5[2] = 32'hE0E00100;
    for (int i = 0; i < 3; i++) begin
      a = 8'hFE + 8'(i);
      drive(1'b0, 8'h00, 1'b1, 2'b00, a, exp5[i]);
      tick();
    end
    drive(1'b0, 8'h00, 1'b1, 2'b00, 8'h50, 32'h5555AAAA);
    tick();

    // 3: read colliding with a write, then two more reads
    drive(1'b1, 8'h01, 1'b1, 2'b00, 8'h02, 32'h22);
    tick();
    check("t3_lvl_a", 64'(pq_level), 64'd1);
    drive(1'b1, 8'h03, 1'b0, 2'b00, 8'h00, 32'h0);
    tick();
    check("t3_lvl_b", 64'(pq_level), 64'd1);
    drive(1'b1, 8'h04, 1'b0, 2'b00, 8'h00, 32'h0);
    tick();
    idle();
    check("t3_lvl_c", 64'(pq_level), 64'd1);
    check("t3_rsp0", 64'(CBG_to_LSU_bus), rsp(32'hA1));
    tick();
    check("t3_lvl_d", 64'(pq_level), 64'd0);
    check("t3_rsp1", 64'(CBG_to_LSU_bus), rsp(32'hA3));
    tick();
    check("t3_rsp2", 64'(CBG_to_LSU_bus), rsp(32'hA4));
    tick();
    check("t3_after", 64'(CBG_to_LSU_bus), 64'd0);

    // 4: six cycles of write+read overflow the four-entry queue
    for (int i = 0; i < 6; i++) begin
      a = 8'h40 + 8'(i);
      drive(1'b1, a, 1'b1, 2'b00, a, 32'hC0 + 32'(i));
      tick();
      check("t4_level", 64'(pq_level), (i < 3) ? 64'(i + 1) : 64'd4);
    end
    idle();
    check("t4_ovf", 64'(pq_overflow), 64'd1);
    check("t4_cnt", 64'(drop_cnt), 64'd2);
    check("t4_quiet", 64'(CBG_to_LSU_bus), 64'd0);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t4_rsp", 64'(CBG_to_LSU_bus), rsp(32'hC0 + 32'(i)));
      tick();
    end
    check("t4_after", 64'(CBG_to_LSU_bus), 64'd0);
    check("t4_lvl_end", 64'(pq_level), 64'd0);

    // 5: consecutive reads across the address wrap
    for (int i = 0; i < 3; i++) begin
      a = 8'hFE + 8'(i);
      drive(1'b1, a, 1'b0, 2'b00, 8'h00, 32'h0);
      tick();
      if (i >= 1) check("t5_rsp", 64'(CBG_to_LSU_bus), rsp(exp5[i-1]));
    end
    idle();
    tick();
    check("t5_rsp_last", 64'(CBG_to_LSU_bus), rsp(exp5[2]));
    tick();
    check("t5_after", 64'(CBG_to_LSU_bus), 64'd0);

    // 6: asynchronous reset with reads in flight and three queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h50, 1'b1, 2'b00, 8'h60, 32'h66);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'h50, 1'b0, 2'b00, 8'h00, 32'h0);
      tick();
    end
    idle();
    check("t6_pre_bus", 64'(CBG_to_LSU_bus), rsp(32'h5555AAAA));
    check("t6_pre_lvl", 64'(pq_level), 64'd3);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_bus", 64'(CBG_to_LSU_bus), 64'd0);
    check("t6_rst_lvl", 64'(pq_level), 64'd0);
    check("t6_rst_ovf", 64'(pq_overflow), 64'd0);
    check("t6_rst_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t6_no_valid", 64'(CBG_to_LSU_bus), 64'd0);
    end
    drive(1'b1, 8'h50, 1'b0, 2'b00, 8'h00, 32'h0);
    tick();
    idle();
    tick();
    check("t6_mem_kept", 64'(CBG_to_LSU_bus), rsp(32'h5555AAAA));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
